calc_input_ctrl: RTL and testbench

CALC_INPUT_CTRL -- requirements
Module: calc_input_ctrl

---
 rtl/calc_input_ctrl.sv | 154 +++++++++++++++
 tb/tb_calc_input_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_input_ctrl.sv
// Input controller for a 4-bit calculator: debounces two push-buttons and
// walks a small entry FSM that latches operand A, operand B and the opcode
// from the slide switches. All outputs come straight from flops.
module calc_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] op,
    output logic       valid,
    output logic       err,
    output logic [1:0] stage
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StEnterA  = 2'd0,
        StEnterB  = 2'd1,
        StEnterOp = 2'd2,
        StReady   = 2'd3
    } state_e;

    // Bit 0 is btn_next, bit 1 is btn_clear throughout.
    logic [1:0]           run_q, run_d;
    logic [1:0]           btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [3:0]           sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [1:0]           lvl_q, lvl_d;
    logic [1:0][CntW-1:0] cnt_q, cnt_d;
    logic [1:0]           press_q, press_d;
    state_e               state_q, state_d;
    logic [3:0]           a_q, a_d, b_q, b_d;
    logic [2:0]           op_q, op_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    // Reset release is synchronized: logic only starts once run_q[1] is set,
    // while assertion still clears everything asynchronously.
    always_comb begin
        run_d    = {run_q[0], 1'b1};
        btn_s1_d = {btn_clear, btn_next};
        btn_s2_d = btn_s1_q;
        sw_s1_d  = sw;
        sw_s2_d  = sw_s1_q;
    end

    // Debounce: a level moves only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_comb begin
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        press_d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (run_q[1]) begin
                if (btn_s2_q[i] != lvl_q[i]) begin
                    if (cnt_q[i] == CntMax) begin
                        lvl_d[i]   = btn_s2_q[i];
                        cnt_d[i]   = '0;
                        press_d[i] = btn_s2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // Entry FSM: clear has priority over next; opcode 3 with b==0 is rejected.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        err_d   = 1'b0;
        if (press_q[1]) begin
            a_d     = 4'd0;
            b_d     = 4'd0;
            op_d    = 3'd0;
            state_d = StEnterA;
        end else if (press_q[0]) begin
            case (state_q)
                StEnterA: begin
                    a_d     = sw_s2_q;
                    state_d = StEnterB;
                end
                StEnterB: begin
                    b_d     = sw_s2_q;
                    state_d = StEnterOp;
                end
                StEnterOp: begin
                    if (sw_s2_q[2:0] == 3'd3 && b_q == 4'd0) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = sw_s2_q[2:0];
                        state_d = StReady;
                    end
                end
                default: state_d = StEnterA;
            endcase
        end
        valid_d = (state_d == StReady);
    end

    // All state, asynchronously cleared by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 2'b00;
            btn_s1_q <= 2'b00;
            btn_s2_q <= 2'b00;
            sw_s1_q  <= 4'd0;
            sw_s2_q  <= 4'd0;
            lvl_q    <= 2'b00;
            cnt_q    <= '0;
            press_q  <= 2'b00;
            state_q  <= StEnterA;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 3'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            run_q    <= run_d;
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            lvl_q    <= lvl_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign op    = op_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign stage = state_q;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Self-checking bench for calc_input_ctrl with DEBOUNCE_CYCLES=16.
module tb_calc_input_ctrl;

    localparam int N = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_clear;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       valid;
    logic       err;
    logic [1:0] stage;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       valid;
        logic [1:0] stage;
        logic [1:0] errc;
        logic       timing_ok;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    string name_q[$];

    // Reference model of the entry registers.
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [2:0] m_op;
    logic [1:0] m_st;

    int n_cmp  = 0;
    int n_fail = 0;

    calc_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_next  (btn_next),
        .btn_clear (btn_clear),
        .a         (a),
        .b         (b),
        .op        (op),
        .valid     (valid),
        .err       (err),
        .stage     (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_model();
        m_a = 4'd0; m_b = 4'd0; m_op = 3'd0; m_st = 2'd0;
    endtask

    // Drive one button press (btns[0]=next, btns[1]=clear), push expected and observed snapshots.
    task automatic press(input logic [1:0] btns, input logic [3:0] swv, input string name);
        snap_t e;
        snap_t o;
        logic [1:0] st0;
        int lat;
        int errc;
        bit seen;
        bit changes;
        sw = swv;
        repeat (4) @(negedge clk);
        changes = 1'b0;
        e.errc  = 2'd0;
        if (btns[1]) begin
            changes = (m_st != 2'd0);
            m_a = 4'd0; m_b = 4'd0; m_op = 3'd0; m_st = 2'd0;
        end else if (btns[0]) begin
            changes = 1'b1;
            case (m_st)
                2'd0: begin m_a = swv; m_st = 2'd1; end
                2'd1: begin m_b = swv; m_st = 2'd2; end
                2'd2: begin
                    if (swv[2:0] == 3'd3 && m_b == 4'd0) e.errc = 2'd1;
                    else begin m_op = swv[2:0]; m_st = 2'd3; end
                end
                default: m_st = 2'd0;
            endcase
        end
        e.a = m_a; e.b = m_b; e.op = m_op; e.valid = (m_st == 2'd3); e.stage = m_st;
        e.timing_ok = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(name);

        st0 = stage;
        btn_next  = btns[0];
        btn_clear = btns[1];
        lat = 0; errc = 0; seen = 1'b0;
        for (int i = 1; i <= N + 12; i++) begin
            @(negedge clk);
            if (err) errc++;
            if (!seen && (stage !== st0 || err)) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            @(negedge clk);
            if (err) errc++;
        end
        o.a = a; o.b = b; o.op = op; o.valid = valid; o.stage = stage;
        o.errc = (errc > 3) ? 2'd3 : 2'(errc);
        if (changes) o.timing_ok = seen && (lat >= N + 3) && (lat <= N + 5);
        else         o.timing_ok = !seen;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 4'd0; btn_next = 1'b0; btn_clear = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        n_cmp++; if ({a, b, op, valid, err, stage} !== 15'd0) begin
            n_fail++; $display("FAIL reset_held: got %h want 0", {a, b, op, valid, err, stage});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (a !== 4'd0) begin n_fail++; $display("FAIL reset_a: got %0h want 0", a); end
        n_cmp++; if (b !== 4'd0) begin n_fail++; $display("FAIL reset_b: got %0h want 0", b); end
        n_cmp++; if (op !== 3'd0) begin n_fail++; $display("FAIL reset_op: got %0d want 0", op); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (stage !== 2'd0) begin n_fail++; $display("FAIL reset_stage: got %0d want 0", stage); end
    endtask

    task automatic test_clean_entry();
        snap_t e;
        snap_t o;
        string nm;
        press(2'b01, 4'd3, "clean_a");
        press(2'b01, 4'd2, "clean_b");
        press(2'b01, 4'd0, "clean_op");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b, want a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b",
                         nm, o.a, o.b, o.op, o.valid, o.stage, o.errc, o.timing_ok,
                         e.a, e.b, e.op, e.valid, e.stage, e.errc, e.timing_ok);
            end
        end
        n_cmp++; if ({a, b, op, valid, stage} !== {4'd3, 4'd2, 3'd0, 1'b1, 2'd3}) begin
            n_fail++; $display("FAIL clean_final: got a=%0h b=%0h op=%0d valid=%b stage=%0d want 3 2 0 1 3",
                               a, b, op, valid, stage);
        end
    endtask

    task automatic test_ready_wrap();
        snap_t e;
        snap_t o;
        string nm;
        press(2'b01, 4'd9, "wrap_ready");
        press(2'b01, 4'hA, "wrap_a");
        press(2'b01, 4'h1, "wrap_b");
        press(2'b01, 4'hD, "wrap_op_sw3_ignored");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b, want a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b",
                         nm, o.a, o.b, o.op, o.valid, o.stage, o.errc, o.timing_ok,
                         e.a, e.b, e.op, e.valid, e.stage, e.errc, e.timing_ok);
            end
        end
    endtask

    task automatic test_div_zero();
        snap_t e;
        snap_t o;
        string nm;
        press(2'b01, 4'd0, "dz_leave_ready");
        press(2'b01, 4'd10, "dz_a");
        press(2'b01, 4'd0, "dz_b");
        press(2'b01, 4'd3, "dz_reject");
        press(2'b01, 4'd6, "dz_accept_xor");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b, want a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b",
                         nm, o.a, o.b, o.op, o.valid, o.stage, o.errc, o.timing_ok,
                         e.a, e.b, e.op, e.valid, e.stage, e.errc, e.timing_ok);
            end
        end
    endtask

    task automatic test_clear_mid();
        snap_t e;
        snap_t o;
        string nm;
        press(2'b10, 4'd5, "clr_from_ready");
        press(2'b01, 4'd15, "clr_a15");
        press(2'b10, 4'd5, "clr_mid_entry");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b, want a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b",
                         nm, o.a, o.b, o.op, o.valid, o.stage, o.errc, o.timing_ok,
                         e.a, e.b, e.op, e.valid, e.stage, e.errc, e.timing_ok);
            end
        end
    endtask

    task automatic test_simultaneous();
        snap_t e;
        snap_t o;
        string nm;
        press(2'b01, 4'd4, "sim_a");
        press(2'b11, 4'd7, "sim_both");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b, want a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b",
                         nm, o.a, o.b, o.op, o.valid, o.stage, o.errc, o.timing_ok,
                         e.a, e.b, e.op, e.valid, e.stage, e.errc, e.timing_ok);
            end
        end
    endtask

    task automatic test_bounce();
        int early;
        int late;
        logic [1:0] prev;
        sw = 4'd5;
        repeat (4) @(negedge clk);
        early = 0; late = 0;
        prev  = stage;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) btn_next = ~btn_next;
            @(negedge clk);
            if (stage !== prev) early++;
            prev = stage;
        end
        btn_next = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (stage !== prev) late++;
            prev = stage;
        end
        btn_next = 1'b0;
        repeat (N + 8) @(negedge clk);
        m_a = 4'd5; m_st = 2'd1;
        n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL bounce_early: got %0d advances want 0", early); end
        n_cmp++; if (late !== 1) begin n_fail++; $display("FAIL bounce_held: got %0d advances want 1", late); end
        n_cmp++; if (stage !== 2'd1) begin n_fail++; $display("FAIL bounce_stage: got %0d want 1", stage); end
        n_cmp++; if (a !== 4'd5) begin n_fail++; $display("FAIL bounce_a: got %0h want 5", a); end
    endtask

    task automatic test_async_reset();
        snap_t e;
        snap_t o;
        string nm;
        press(2'b10, 4'd0, "ar_clear");
        press(2'b01, 4'd1, "ar_a");
        press(2'b01, 4'd0, "ar_b");
        press(2'b01, 4'd7, "ar_op_not");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b, want a=%0h b=%0h op=%0d valid=%b stage=%0d errc=%0d tim=%b",
                         nm, o.a, o.b, o.op, o.valid, o.stage, o.errc, o.timing_ok,
                         e.a, e.b, e.op, e.valid, e.stage, e.errc, e.timing_ok);
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        n_cmp++; if (a !== 4'd0) begin n_fail++; $display("FAIL async_a: got %0h want 0", a); end
        n_cmp++; if (op !== 3'd0) begin n_fail++; $display("FAIL async_op: got %0d want 0", op); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", valid); end
        n_cmp++; if (stage !== 2'd0) begin n_fail++; $display("FAIL async_stage: got %0d want 0", stage); end
        n_cmp++; if ({b, err} !== 5'd0) begin n_fail++; $display("FAIL async_b_err: got %h want 0", {b, err}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_held();
        int adv;
        logic [1:0] prev;
        rst_n = 1'b0;
        sw = 4'd9;
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        adv = 0;
        prev = stage;
        for (int c = 0; c < 2 * N + 10; c++) begin
            @(negedge clk);
            if (stage !== prev) adv++;
            prev = stage;
        end
        btn_next = 1'b0;
        repeat (N + 8) @(negedge clk);
        m_a = 4'd9; m_st = 2'd1;
        n_cmp++; if (adv !== 1) begin n_fail++; $display("FAIL held_through_reset_adv: got %0d want 1", adv); end
        n_cmp++; if (stage !== 2'd1) begin n_fail++; $display("FAIL held_through_reset_stage: got %0d want 1", stage); end
        n_cmp++; if (a !== 4'd9) begin n_fail++; $display("FAIL held_through_reset_a: got %0h want 9", a); end
    endtask

    initial begin
        test_reset();
        test_clean_entry();
        test_ready_wrap();
        test_div_zero();
        test_clear_mid();
        test_simultaneous();
        test_bounce();
        test_async_reset();
        test_reset_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
